led_pwm_pio: RTL and testbench

LED_PWM_PIO -- requirements
Module: led_pwm_pio

---
 rtl/led_pio_pkg.sv | 41 ++++
 rtl/led_pwm_pio_if.sv | 20 ++
 rtl/led_pwm_channel.sv | 47 ++++
 rtl/led_pwm_pio.sv | 129 ++++++++++++
 tb/tb_led_pwm_pio.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/led_pio_pkg.sv
// Shared register map, address width and decode helpers for the LED PWM PIO.
package led_pio_pkg;

  localparam int unsigned ADDR_W    = 6;
  localparam int unsigned DUTY_BASE = 4;

  localparam logic [ADDR_W-1:0] OFS_DATA  = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] OFS_PWMEN = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] OFS_BLINK = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] OFS_PRESC = ADDR_W'(3);

  typedef enum logic [2:0] {
    REG_NONE,
    REG_DATA,
    REG_PWMEN,
    REG_BLINK,
    REG_PRESC,
    REG_DUTY
  } reg_sel_e;

  function automatic logic [ADDR_W-1:0] duty_addr(input int unsigned ch);
    return ADDR_W'(DUTY_BASE + ch);
  endfunction

  function automatic reg_sel_e reg_decode(input logic [ADDR_W-1:0] addr,
                                          input int unsigned num_ch);
    reg_sel_e sel;
    sel = REG_NONE;
    case (addr)
      OFS_DATA:  sel = REG_DATA;
      OFS_PWMEN: sel = REG_PWMEN;
      OFS_BLINK: sel = REG_BLINK;
      OFS_PRESC: sel = REG_PRESC;
      default: begin
        if ((32'(addr) >= DUTY_BASE) && (32'(addr) < DUTY_BASE + num_ch)) sel = REG_DUTY;
      end
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/led_pwm_pio_if.sv
// Avalon-MM slave bus bundle for the LED PWM PIO.
interface led_pwm_pio_if;
  import led_pio_pkg::*;

  logic [ADDR_W-1:0] avs_address;
  logic              avs_read;
  logic              avs_write;
  logic [31:0]       avs_writedata;
  logic [31:0]       avs_readdata;

  modport master (
    output avs_address, avs_read, avs_write, avs_writedata,
    input  avs_readdata
  );

  modport slave (
    input  avs_address, avs_read, avs_write, avs_writedata,
    output avs_readdata
  );
endinterface

// File: rtl/led_pwm_channel.sv
// One LED channel: shadow/active duty pair, duty compare and registered output gate.
module led_pwm_channel #(
  parameter int unsigned PWM_BITS = 8
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                duty_we_i,
  input  logic [PWM_BITS-1:0] duty_wdata_i,
  input  logic                period_start_i,
  input  logic [PWM_BITS-1:0] period_cnt_i,
  input  logic                data_i,
  input  logic                pwmen_i,
  input  logic                blink_i,
  input  logic                phase_i,
  output logic [PWM_BITS-1:0] shadow_o,
  output logic                led_o
);

  logic [PWM_BITS-1:0] shadow_q, shadow_d;
  logic [PWM_BITS-1:0] active_q, active_d;
  logic                led_q, led_d;
  logic                pwm;

  // Active duty only changes on a period boundary so a period is never cut short.
  always_comb begin
    shadow_d = duty_we_i ? duty_wdata_i : shadow_q;
    active_d = period_start_i ? shadow_q : active_q;
    pwm      = (active_q > period_cnt_i);
    led_d    = data_i & (pwmen_i ? pwm : 1'b1) & (blink_i ? phase_i : 1'b1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shadow_q <= '0;
      active_q <= '0;
      led_q    <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
      led_q    <= led_d;
    end
  end

  assign shadow_o = shadow_q;
  assign led_o    = led_q;

endmodule

// File: rtl/led_pwm_pio.sv
// LED PIO with per-channel PWM dimming and blink; shared prescaler, period counter and phase.
module led_pwm_pio
  import led_pio_pkg::*;
#(
  parameter int unsigned NUM_CH   = 8,
  parameter int unsigned PWM_BITS = 8,
  parameter int unsigned PRESC_W  = 16
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  output logic [31:0]       avs_readdata,
  output logic [NUM_CH-1:0] leds_export
);

  reg_sel_e            sel;
  logic [NUM_CH-1:0]   data_q, data_d;
  logic [NUM_CH-1:0]   pwmen_q, pwmen_d;
  logic [NUM_CH-1:0]   blink_q, blink_d;
  logic [PRESC_W-1:0]  presc_q, presc_d;
  logic [PRESC_W-1:0]  psc_cnt_q, psc_cnt_d;
  logic [PWM_BITS-1:0] per_q, per_d;
  logic                phase_q, phase_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                tick;
  logic                period_start;
  logic [NUM_CH-1:0]   duty_we;
  logic [NUM_CH-1:0]   led;
  logic [PWM_BITS-1:0] shadow [NUM_CH];
  logic                unused_wdata;

  assign sel          = reg_decode(avs_address, NUM_CH);
  assign unused_wdata = ^avs_writedata;

  always_comb begin
    data_d  = data_q;
    pwmen_d = pwmen_q;
    blink_d = blink_q;
    presc_d = presc_q;
    if (avs_write) begin
      case (sel)
        REG_DATA:  data_d  = avs_writedata[NUM_CH-1:0];
        REG_PWMEN: pwmen_d = avs_writedata[NUM_CH-1:0];
        REG_BLINK: blink_d = avs_writedata[NUM_CH-1:0];
        REG_PRESC: presc_d = avs_writedata[PRESC_W-1:0];
        default: ;
      endcase
    end
  end

  always_comb begin
    tick      = (psc_cnt_q == presc_q);
    psc_cnt_d = tick ? '0 : psc_cnt_q + PRESC_W'(1);
    if (avs_write && (sel == REG_PRESC)) psc_cnt_d = '0;
    period_start = tick && (per_q == '1);
    per_d        = tick ? per_q + PWM_BITS'(1) : per_q;
    phase_d      = phase_q ^ period_start;
  end

  // Read mux sees pre-edge register values, so a same-cycle write returns the old value.
  always_comb begin
    rdata_d = rdata_q;
    if (avs_read) begin
      rdata_d = '0;
      case (sel)
        REG_DATA:  rdata_d = 32'(data_q);
        REG_PWMEN: rdata_d = 32'(pwmen_q);
        REG_BLINK: rdata_d = 32'(blink_q);
        REG_PRESC: rdata_d = 32'(presc_q);
        REG_DUTY: begin
          for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (avs_address == duty_addr(i)) rdata_d = 32'(shadow[i]);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      data_q    <= '0;
      pwmen_q   <= '0;
      blink_q   <= '0;
      presc_q   <= '0;
      psc_cnt_q <= '0;
      per_q     <= '0;
      phase_q   <= 1'b0;
      rdata_q   <= '0;
    end else begin
      data_q    <= data_d;
      pwmen_q   <= pwmen_d;
      blink_q   <= blink_d;
      presc_q   <= presc_d;
      psc_cnt_q <= psc_cnt_d;
      per_q     <= per_d;
      phase_q   <= phase_d;
      rdata_q   <= rdata_d;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign duty_we[g] = avs_write && (avs_address == duty_addr(g));

    led_pwm_channel #(
      .PWM_BITS(PWM_BITS)
    ) u_ch (
      .clk_i         (clk_clk),
      .rst_ni        (reset_reset_n),
      .duty_we_i     (duty_we[g]),
      .duty_wdata_i  (avs_writedata[PWM_BITS-1:0]),
      .period_start_i(period_start),
      .period_cnt_i  (per_q),
      .data_i        (data_q[g]),
      .pwmen_i       (pwmen_q[g]),
      .blink_i       (blink_q[g]),
      .phase_i       (phase_q),
      .shadow_o      (shadow[g]),
      .led_o         (led[g])
    );
  end

  assign avs_readdata = rdata_q;
  assign leds_export  = led;

endmodule

// File: tb/tb_led_pwm_pio.sv
// Scoreboard bench for led_pwm_pio: driver queues expectations, monitor compares on DUT outputs.
module tb_led_pwm_pio;
  import led_pio_pkg::*;

  localparam int unsigned NUM_CH   = 8;
  localparam int unsigned PWM_BITS = 8;
  localparam int unsigned PRESC_W  = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  led_pwm_pio_if bus ();
  logic [NUM_CH-1:0] leds;

  led_pwm_pio #(
    .NUM_CH  (NUM_CH),
    .PWM_BITS(PWM_BITS),
    .PRESC_W (PRESC_W)
  ) dut (
    .clk_clk      (clk),
    .reset_reset_n(rst_n),
    .avs_address  (bus.avs_address),
    .avs_read     (bus.avs_read),
    .avs_write    (bus.avs_write),
    .avs_writedata(bus.avs_writedata),
    .avs_readdata (bus.avs_readdata),
    .leds_export  (leds)
  );

  typedef struct {
    string       name;
    logic [31:0] exp;
  } exp_t;

  exp_t rd_q[$];
  exp_t led_q[$];
  exp_t cnt_q[$];
  exp_t e;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic        rd_pend  = 1'b0;
  logic        led_probe = 1'b0;
  logic        cnt_probe = 1'b0;
  logic        to_probe  = 1'b0;
  logic        done_probe = 1'b0;
  logic        win   = 1'b0;
  logic        win_d = 1'b0;
  int unsigned cnt_sel = 0;
  int          cnt = 0;
  string       to_name = "";

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_pend <= 1'b0;
    else        rd_pend <= bus.avs_read;
  end

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, got, exp);
    end
  endtask

  // Monitor: all comparisons happen here, on the falling edge.
  always @(negedge clk) begin
    if (rd_pend) begin
      if (rd_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_read: got 0x%08h with no expectation queued", bus.avs_readdata);
      end else begin
        e = rd_q.pop_front();
        check(e.name, bus.avs_readdata, e.exp);
      end
    end
    if (led_probe && led_q.size() != 0) begin
      e = led_q.pop_front();
      check(e.name, 32'(leds), e.exp);
    end
    if (cnt_probe && cnt_q.size() != 0) begin
      e = cnt_q.pop_front();
      check(e.name, 32'(cnt), e.exp);
      cnt = 0;
    end
    if (to_probe) begin
      n_checks++; n_fail++;
      $display("FAIL %s: got no rising edge expected one within the cycle budget", to_name);
    end
    if (done_probe) check("queues_drained", 32'(rd_q.size() + led_q.size() + cnt_q.size()), 32'h0);
    if (win) begin
      if (!win_d) cnt = 0;
      cnt += int'(leds[cnt_sel]);
    end
    win_d = win;
  end

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d);
    bus.avs_address = a; bus.avs_writedata = d; bus.avs_write = 1'b1;
    cycles(1);
    bus.avs_write = 1'b0;
  endtask

  task automatic rd(input string nm, input logic [5:0] a, input logic [31:0] exp);
    rd_q.push_back('{nm, exp});
    bus.avs_address = a; bus.avs_read = 1'b1;
    cycles(1);
    bus.avs_read = 1'b0;
  endtask

  task automatic rw(input string nm, input logic [5:0] a, input logic [31:0] d,
                    input logic [31:0] exp);
    rd_q.push_back('{nm, exp});
    bus.avs_address = a; bus.avs_writedata = d;
    bus.avs_read = 1'b1; bus.avs_write = 1'b1;
    cycles(1);
    bus.avs_read = 1'b0; bus.avs_write = 1'b0;
  endtask

  task automatic led_chk(input string nm, input logic [31:0] exp);
    led_q.push_back('{nm, exp});
    led_probe = 1'b1;
    cycles(1);
    led_probe = 1'b0;
  endtask

  task automatic cnt_chk(input string nm, input logic [31:0] exp);
    cnt_q.push_back('{nm, exp});
    cnt_probe = 1'b1;
    cycles(1);
    cnt_probe = 1'b0;
  endtask

  // Returns right after the first cycle in which leds[ch] reads 1 having read 0 before.
  task automatic sync_rise(input string nm, input int unsigned ch, input int limit);
    logic prev;
    bit   seen;
    prev = leds[ch];
    seen = 1'b0;
    for (int k = 0; k < limit && !seen; k++) begin
      cycles(1);
      if (leds[ch] && !prev) seen = 1'b1;
      prev = leds[ch];
    end
    if (!seen) begin
      to_name = nm; to_probe = 1'b1;
      cycles(1);
      to_probe = 1'b0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test expected one within 50000 cycles");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.avs_address = '0; bus.avs_read = 1'b0; bus.avs_write = 1'b0; bus.avs_writedata = '0;
    cycles(3);
    led_chk("rst_hold_leds", 32'h0);
    rst_n = 1'b1;
    cycles(2);

    led_chk("rst_leds", 32'h0);
    for (int a = 0; a < 12; a++) rd($sformatf("rst_rd%0d", a), 6'(a), 32'h0);
    rd("rst_rd63", 6'd63, 32'h0);

    // Static drive and two-cycle write-to-LED latency.
    wr(6'd0, 32'hA5);
    led_chk("data_lat1", 32'h00);
    led_chk("data_lat2", 32'hA5);
    rd("rd_data", 6'd0, 32'h0000_00A5);

    // Upper bits and unmapped writes are dropped.
    wr(6'd0, 32'hFFFF_FF5A);  rd("data_upper", 6'd0, 32'h5A);
    wr(6'd3, 32'hFFFF_0003);  rd("presc_upper", 6'd3, 32'h3);
    wr(6'd3, 32'h0);
    wr(6'd12, 32'hFFFF_FFFF); rd("unmapped12", 6'd12, 32'h0);
    wr(6'd11, 32'hFFFF_FF80); rd("duty7_upper", 6'd11, 32'h80);

    rw("rw_prewrite", 6'd0, 32'h01, 32'h5A);
    rd("rw_postwrite", 6'd0, 32'h01);

    // PWM duty 64 with a tick every cycle.
    wr(6'd1, 32'h01);
    wr(6'd4, 32'd64);
    rd("rd_duty0", 6'd4, 32'd64);
    cycles(600);
    cnt_sel = 0;
    sync_rise("pwm_sync", 0, 600);
    win = 1'b1;
    cycles(256);
    cnt_chk("pwm_period1", 32'd64);
    cycles(255);
    cnt_chk("pwm_period2", 32'd64);
    win = 1'b0;

    // Shadow duty written mid-period lands on the next period.
    sync_rise("shadow_sync", 0, 600);
    win = 1'b1;
    cycles(10);
    wr(6'd4, 32'd200);
    cycles(245);
    cnt_chk("shadow_current", 32'd64);
    cycles(255);
    cnt_chk("shadow_next", 32'd200);
    win = 1'b0;

    wr(6'd4, 32'd0);
    cycles(600);
    win = 1'b1;
    cycles(256);
    cnt_chk("duty_zero", 32'd0);
    win = 1'b0;

    wr(6'd4, 32'd255);
    cycles(600);
    win = 1'b1;
    cycles(256);
    cnt_chk("duty_full", 32'd255);
    win = 1'b0;

    // Blink on channel 1 with PRESC = 1: 512 cycles per phase.
    wr(6'd0, 32'h02);
    wr(6'd2, 32'h02);
    wr(6'd3, 32'h01);
    cnt_sel = 1;
    cycles(20);
    win = 1'b1;
    cycles(1024);
    cnt_chk("blink_duty", 32'd512);
    win = 1'b0;
    sync_rise("blink_sync", 1, 2000);
    win = 1'b1;
    cycles(512);
    cnt_chk("blink_on", 32'd512);
    cycles(511);
    cnt_chk("blink_off", 32'd0);
    win = 1'b0;

    rd("rd63_live", 6'd63, 32'h0);

    // Reset mid-operation, then confirm the period restarts from zero.
    wr(6'd2, 32'h0);
    cycles(2);
    led_chk("pre_reset", 32'h02);
    rst_n = 1'b0;
    led_chk("reset_async", 32'h0);
    cycles(2);
    rst_n = 1'b1;
    wr(6'd0, 32'h01);
    wr(6'd1, 32'h01);
    wr(6'd4, 32'd128);
    cycles(252);
    led_chk("rel_tick255", 32'h0);
    led_chk("rel_tick256", 32'h0);
    led_chk("rel_tick257", 32'h01);
    rd("post_rst_blink", 6'd2, 32'h0);
    rd("post_rst_presc", 6'd3, 32'h0);
    rd("post_rst_duty1", 6'd5, 32'h0);
    rd("post_rst_duty7", 6'd11, 32'h0);

    cycles(2);
    done_probe = 1'b1;
    cycles(1);
    done_probe = 1'b0;
    cycles(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
